vga_sync_receiver: RTL and testbench

- Receive end of our 640x480 VGA timing: samples active-low hsync/vsync (one pixel per clk_i), measures line and frame geometry, locks after consecutive identical frames, and regenerates pixel column/row and display-active.
- Used for loopback checking of the timing generator and as the front end of a future video-capture path.

---
 rtl/vga_sync_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Receive side of the 640x480 VGA timing. Samples active-low hsync/vsync
//   (one pixel per clk_i), measures clocks per line and lines per frame,
//   locks once consecutive frames agree, and regenerates column/row and the
//   display-active window from the recovered counters.
//
//   Ports:
//     clk_i          pixel clock
//     rst_i          synchronous, active-high reset
//     hsync_i        active-low horizontal sync
//     vsync_i        active-low vertical sync
//     locked_o       geometry stable (state LOCKED)
//     h_period_o     last measured clocks per line
//     v_lines_o      last measured lines per frame
//     xcol_o/yrow_o  recovered column/row, 0 outside the active window
//     disp_active_o  recovered active region, gated by lock
//     frame_start_o  one-clock pulse when the line counter restarts
//     err_o          one-clock pulse on a geometry mismatch while locked
//     err_cnt_o      saturating error/timeout count (only with VGA_RX_ERRCNT_EN)
//
//   Build option: define VGA_RX_ERRCNT_EN to add err_cnt_o.
module vga_sync_receiver #(
  parameter int unsigned H_ACT_START = 139,
  parameter int unsigned H_DISP      = 640,
  parameter int unsigned V_ACT_START = 29,
  parameter int unsigned V_DISP      = 480,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic        locked_o,
  output logic [11:0] h_period_o,
  output logic [11:0] v_lines_o,
  output logic [9:0]  xcol_o,
  output logic [9:0]  yrow_o,
  output logic        disp_active_o,
  output logic        frame_start_o,
  output logic        err_o
`ifdef VGA_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt_o
`endif
);

  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_e;

  localparam logic [11:0] CNT_MAX = '1;
  localparam logic [11:0] H_LO    = 12'(H_ACT_START);
  localparam logic [11:0] H_HI    = 12'(H_ACT_START + H_DISP);
  localparam logic [11:0] V_LO    = 12'(V_ACT_START);
  localparam logic [11:0] V_HI    = 12'(V_ACT_START + V_DISP);
  localparam logic [11:0] TO_CNT  = 12'(TIMEOUT);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic        hs_q, vs_q;
  logic        vpend_q, vpend_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] h_period_q, h_period_d;
  logic [11:0] v_lines_q, v_lines_d;
  logic [3:0]  match_q, match_d;
  logic        fs_q, fs_d;
  logic        err_q, err_d;

  logic        hfall, vfall, fs_evt, timeout;
  logic [11:0] h_meas, v_meas;
  logic        h_diff, v_diff;
  logic        h_in, v_in;
  logic [9:0]  x_off, y_off;

  assign hfall  = hs_q & ~hsync_i;
  assign vfall  = vs_q & ~vsync_i;
  assign fs_evt = hfall & (vpend_q | vfall);

  // Saturating "+1": used both as the measurement and as the counter step,
  // so neither the counters nor the measured values can wrap.
  assign h_meas = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 12'd1;
  assign v_meas = (v_cnt_q == CNT_MAX) ? CNT_MAX : v_cnt_q + 12'd1;
  assign h_diff = (h_meas != h_period_q);
  assign v_diff = (v_meas != v_lines_q);

  // An hsync fall clears h_cnt this edge, so a stale saturated count must not
  // also throw the FSM back to SEARCH on the very edge that resumes sync.
  assign timeout = (h_cnt_q >= TO_CNT) && !hfall;

  always_comb begin
    h_cnt_d    = hfall ? '0 : h_meas;
    h_period_d = hfall ? h_meas : h_period_q;
    v_cnt_d    = v_cnt_q;
    v_lines_d  = v_lines_q;
    vpend_d    = vpend_q | vfall;
    fs_d       = 1'b0;
    if (hfall) begin
      if (vpend_q || vfall) begin
        v_cnt_d   = '0;
        v_lines_d = v_meas;
        vpend_d   = 1'b0;
        fs_d      = 1'b1;
      end else begin
        v_cnt_d   = v_meas;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_d   = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      match_d = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (fs_evt) begin
            state_d = TRAIN;
            match_d = '0;
          end
        end
        TRAIN: begin
          if (fs_evt) begin
            if (!h_diff && !v_diff) begin
              match_d = match_q + 4'd1;
              if (match_q + 4'd1 >= LOCK_N) state_d = LOCKED;
            end else begin
              match_d = '0;
            end
          end else if (hfall && h_diff) begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if ((hfall && h_diff) || (fs_evt && v_diff)) begin
            err_d   = 1'b1;
            state_d = TRAIN;
            match_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SEARCH;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      vpend_q    <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      h_period_q <= '0;
      v_lines_q  <= '0;
      match_q    <= '0;
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_q       <= hsync_i;
      vs_q       <= vsync_i;
      vpend_q    <= vpend_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      h_period_q <= h_period_d;
      v_lines_q  <= v_lines_d;
      match_q    <= match_d;
      fs_q       <= fs_d;
      err_q      <= err_d;
    end
  end

  assign h_in  = (h_cnt_q >= H_LO) && (h_cnt_q < H_HI);
  assign v_in  = (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);
  assign x_off = h_cnt_q[9:0] - H_LO[9:0];
  assign y_off = v_cnt_q[9:0] - V_LO[9:0];

  assign locked_o      = (state_q == LOCKED);
  assign disp_active_o = locked_o && h_in && v_in;
  assign xcol_o        = disp_active_o ? x_off : '0;
  assign yrow_o        = disp_active_o ? y_off : '0;
  assign h_period_o    = h_period_q;
  assign v_lines_o     = v_lines_q;
  assign frame_start_o = fs_q;
  assign err_o         = err_q;

`ifdef VGA_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_d || (timeout && state_q != SEARCH)) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver
//   Directed bench for vga_sync_receiver using a scaled-down timing generator
//   (40 clocks/line, hsync low 4, 12 lines/frame, vsync low 2 lines) so the
//   whole sequence stays short. Receiver window: h_cnt 9..32, v_cnt 3..10.
//   Generator position (gx, gy) is the vector about to be driven; after the
//   edge that consumed vector gx-1 the receiver's h_cnt equals gx-1.
module tb_vga_sync_receiver;

  localparam int HT = 40;
  localparam int HS = 4;
  localparam int VT = 12;
  localparam int VS = 2;
  localparam int STRETCH_LINE = 5;
  localparam int BOUND = 2000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        hsync_i;
  logic        vsync_i;
  logic        locked_o;
  logic [11:0] h_period_o;
  logic [11:0] v_lines_o;
  logic [9:0]  xcol_o;
  logic [9:0]  yrow_o;
  logic        disp_active_o;
  logic        frame_start_o;
  logic        err_o;
`ifdef VGA_RX_ERRCNT_EN
  logic [7:0]  err_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int gx = 0;
  int gy = 0;
  bit gen_on = 1'b0;
  bit stretch = 1'b0;
  int err_seen = 0;

  vga_sync_receiver #(
    .H_ACT_START(9),
    .H_DISP     (24),
    .V_ACT_START(3),
    .V_DISP     (8),
    .LOCK_FRAMES(2),
    .TIMEOUT    (300)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .locked_o     (locked_o),
    .h_period_o   (h_period_o),
    .v_lines_o    (v_lines_o),
    .xcol_o       (xcol_o),
    .yrow_o       (yrow_o),
    .disp_active_o(disp_active_o),
    .frame_start_o(frame_start_o),
    .err_o        (err_o)
`ifdef VGA_RX_ERRCNT_EN
    ,
    .err_cnt_o    (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic gen_cycle();
    int len;
    hsync_i = !(gen_on && gx < HS);
    vsync_i = !(gen_on && gy < VS);
    @(posedge clk);
    #1;
    if (err_o) err_seen++;
    if (gen_on) begin
      len = (stretch && gy == STRETCH_LINE) ? HT + 1 : HT;
      gx++;
      if (gx >= len) begin
        gx = 0;
        gy = (gy + 1) % VT;
      end
    end
  endtask

  task automatic run_to(input int x, input int y);
    int n;
    n = 0;
    while (!(gx == x && gy == y) && n < BOUND) begin
      gen_cycle();
      n++;
    end
    if (n >= BOUND) check_eq($sformatf("run_to_%0d_%0d_bound", x, y), n, 0);
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      gen_cycle();
      n++;
    end while (!frame_start_o && n < BOUND);
    if (!frame_start_o) check_eq({tag, "_fs_bound"}, n, 0);
  endtask

  // The first frame_start moves SEARCH->TRAIN; LOCKED is expected on the
  // third frame_start after that (index 4 here).
  task automatic lock_seq(input int first_k, input string tag);
    for (int k = first_k; k <= 4; k++) begin
      wait_fs(tag);
      check_eq($sformatf("%s_locked_fs%0d", tag, k), locked_o, (k == 4) ? 1 : 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i   = 1'b1;
    hsync_i = 1'b1;
    vsync_i = 1'b1;
    repeat (3) gen_cycle();
    check_eq("rst_locked",   locked_o,      0);
    check_eq("rst_h_period", h_period_o,    0);
    check_eq("rst_v_lines",  v_lines_o,     0);
    check_eq("rst_xcol",     xcol_o,        0);
    check_eq("rst_yrow",     yrow_o,        0);
    check_eq("rst_disp",     disp_active_o, 0);
    check_eq("rst_fs",       frame_start_o, 0);
    check_eq("rst_err",      err_o,         0);
`ifdef VGA_RX_ERRCNT_EN
    check_eq("rst_err_cnt",  err_cnt_o,     0);
`endif
    rst_i = 1'b0;
    gen_cycle();

    // Nominal lock; every frame start has vsync and hsync falling together.
    gen_on = 1'b1;
    gx = 0;
    gy = 0;
    lock_seq(1, "nom");
    check_eq("nom_h_period", h_period_o, HT);
    check_eq("nom_v_lines",  v_lines_o,  VT);
    gen_cycle();
    check_eq("nom_fs_width", frame_start_o, 0);
    check_eq("nom_no_err",   err_seen,      0);

    // Active window edges.
    run_to(9, 3);
    check_eq("col_m1_disp", disp_active_o, 0);
    run_to(10, 3);
    check_eq("c0r0_disp", disp_active_o, 1);
    check_eq("c0r0_xcol", xcol_o, 0);
    check_eq("c0r0_yrow", yrow_o, 0);
    run_to(33, 10);
    check_eq("clast_disp", disp_active_o, 1);
    check_eq("clast_xcol", xcol_o, 23);
    check_eq("clast_yrow", yrow_o, 7);
    run_to(34, 10);
    check_eq("cpast_disp", disp_active_o, 0);
    check_eq("cpast_xcol", xcol_o, 0);
    run_to(10, 11);
    check_eq("rpast_disp", disp_active_o, 0);
    check_eq("rpast_yrow", yrow_o, 0);

    // One line stretched by a clock.
    run_to(0, STRETCH_LINE);
    stretch  = 1'b1;
    err_seen = 0;
    run_to(1, STRETCH_LINE + 1);
    stretch = 1'b0;
    check_eq("str_err",      err_o,    1);
    check_eq("str_unlocked", locked_o, 0);
    gen_cycle();
    check_eq("str_err_clr",  err_o,    0);
    lock_seq(3, "str");
    check_eq("str_err_pulses", err_seen,   1);
    check_eq("str_h_period",   h_period_o, HT);
`ifdef VGA_RX_ERRCNT_EN
    check_eq("str_err_cnt", err_cnt_o, 1);
`endif

    // Sync loss: h_cnt stopped at 19 reaches 300 after 281 idle clocks.
    run_to(20, 4);
    gen_on = 1'b0;
    repeat (270) gen_cycle();
    check_eq("to_still_locked", locked_o, 1);
    repeat (20) gen_cycle();
    check_eq("to_locked", locked_o,      0);
    check_eq("to_disp",   disp_active_o, 0);
    check_eq("to_xcol",   xcol_o,        0);
    check_eq("to_yrow",   yrow_o,        0);
    check_eq("to_no_err", err_seen,      1);
`ifdef VGA_RX_ERRCNT_EN
    check_eq("to_err_cnt", err_cnt_o, 2);
`endif
    repeat (4200) gen_cycle();
    gen_on = 1'b1;
    gx = 0;
    gy = 0;
    gen_cycle();
    check_eq("sat_fs",       frame_start_o, 1);
    check_eq("sat_h_period", h_period_o,    12'hFFF);
    check_eq("sat_v_lines",  v_lines_o,     5);
    check_eq("sat_locked",   locked_o,      0);
    lock_seq(2, "to");

    // Reset in the middle of an active line while locked.
    run_to(15, 5);
    check_eq("pre_rst_disp", disp_active_o, 1);
    check_eq("pre_rst_xcol", xcol_o, 5);
    check_eq("pre_rst_yrow", yrow_o, 2);
    rst_i = 1'b1;
    gen_cycle();
    check_eq("mrst_locked",   locked_o,      0);
    check_eq("mrst_h_period", h_period_o,    0);
    check_eq("mrst_v_lines",  v_lines_o,     0);
    check_eq("mrst_disp",     disp_active_o, 0);
    check_eq("mrst_xcol",     xcol_o,        0);
    check_eq("mrst_yrow",     yrow_o,        0);
    check_eq("mrst_fs",       frame_start_o, 0);
    check_eq("mrst_err",      err_o,         0);
`ifdef VGA_RX_ERRCNT_EN
    check_eq("mrst_err_cnt",  err_cnt_o,     0);
`endif
    rst_i = 1'b0;
    lock_seq(1, "mrst");
    check_eq("mrst_v_lines_relock", v_lines_o, VT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
